// File: rtl/pwm_pkg.sv
// Shared PWM constants and the measurement state type, common to pwm_gen and pwm_meas.
package pwm_pkg;

  localparam int unsigned PWM_PERIOD = 1024;
  localparam int unsigned PWM_DUTY_W = 10;
  localparam int unsigned PWM_CNT_W  = 11;

  typedef enum logic [1:0] {
    IDLE,
    IDLE_HI,
    HIGH,
    LOW
  } meas_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level input, with registered
// previous level and single-cycle rise/fall pulses.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [2:0] fill;

  // Synchronize din and keep the previous synchronized level; fill tracks
  // how many of s1/s2/prev hold real samples since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      fill <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end

  // Edges are qualified until prev holds a real sample, so a line that is
  // already high out of reset does not produce a false rise.
  assign rise = fill[2] & s2 & ~prev;
  assign fall = fill[2] & ~s2 & prev;

endmodule

// File: rtl/pwm_meas.sv
// PWM measurement: counts high time and rising-edge-to-rising-edge period of
// an incoming PWM waveform, recovers the duty word, and flags bad periods and
// stuck lines.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = PWM_CNT_W,
  parameter int unsigned DUTY_W     = PWM_DUTY_W,
  parameter int unsigned NOM_PERIOD = PWM_PERIOD,
  parameter int unsigned TIMEOUT    = 2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              meas_vld,
  output logic              period_err,
  output logic              stuck_hi,
  output logic              stuck_lo
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_NOM = CNT_W'(NOM_PERIOD);

  meas_state_e      state;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] h_lat;
  logic [CNT_W-1:0] hcnt_nx;
  logic [CNT_W-1:0] pcnt_nx;
  logic [CNT_W-1:0] lcnt_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .rise (rise),
    .fall (fall)
  );

  // Saturating next-count values for the high, period and low-run counters.
  always_comb begin
    hcnt_nx = sat_inc(hcnt);
    pcnt_nx = sat_inc(pcnt);
    lcnt_nx = sat_inc(lcnt);
  end

  // Measurement FSM: counts phases, publishes results on each complete
  // period and detects stuck-high / stuck-low lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      pcnt       <= '0;
      lcnt       <= '0;
      h_lat      <= '0;
      duty_out   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_vld   <= 1'b0;
      period_err <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            stuck_lo <= 1'b0;
            hcnt     <= CNT_ONE;
            pcnt     <= CNT_ONE;
            state    <= HIGH;
          end
        end
        IDLE_HI: begin
          if (fall) begin
            stuck_hi <= 1'b0;
            state    <= IDLE;
          end
        end
        HIGH: begin
          pcnt <= pcnt_nx;
          if (fall) begin
            h_lat <= hcnt;
            lcnt  <= CNT_ONE;
            state <= LOW;
          end else begin
            hcnt <= hcnt_nx;
            if (hcnt_nx >= CNT_TO) begin
              stuck_hi <= 1'b1;
              state    <= IDLE_HI;
            end
          end
        end
        LOW: begin
          if (rise) begin
            high_cnt   <= h_lat;
            period_cnt <= pcnt;
            duty_out   <= DUTY_W'(h_lat - CNT_ONE);
            meas_vld   <= 1'b1;
            if (pcnt != CNT_NOM) begin
              period_err <= 1'b1;
            end
            hcnt  <= CNT_ONE;
            pcnt  <= CNT_ONE;
            state <= HIGH;
          end else begin
            pcnt <= pcnt_nx;
            lcnt <= lcnt_nx;
            if (lcnt_nx >= CNT_TO) begin
              stuck_lo <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
